// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer: generates the per-core attention instruction stream
// (Q write, K write, K load, execute, ofifo->pmem, SFP normalize) with
// idle gaps, and the matching mem_in data taken from a Q/K row source.
module qk_inst_sequencer #(
    parameter int BW      = 4,
    parameter int PR      = 16,
    parameter int COL     = 8,
    parameter int Q_DEPTH = 8,
    parameter int ADDR_W  = 4,
    parameter int GAP     = 10,
    parameter int SFP_LEN = 8,
    parameter int INST_W  = 11 + 2 * ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [5:0]           phase_en,
    input  logic [PR*BW-1:0]     data_in,
    input  logic                 data_vld,
    output logic                 data_req,
    output logic                 data_sel,
    output logic [ADDR_W-1:0]    data_idx,
    output logic [INST_W-1:0]    inst,
    output logic [PR*BW-1:0]     mem_out,
    output logic                 sfp_sample,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           phase
);

    // Counter widths: cnt reaches COL+1 during KLOAD, sub holds GAP and SFP cycle counts.
    localparam int CW   = ADDR_W + 1;
    localparam int MAXL = (GAP > SFP_LEN) ? GAP : SFP_LEN;
    localparam int SW   = $clog2(MAXL + 1);

    if (COL > 2**ADDR_W || Q_DEPTH > 2**ADDR_W || SFP_LEN < 7 || GAP < 1 ||
        INST_W != 11 + 2 * ADDR_W) begin : g_bad_params
        $error("qk_inst_sequencer: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_QWR, S_KWR, S_KLOAD, S_EXEC, S_OFIFO, S_SFP, S_GAP, S_DONE
    } state_t;

    typedef struct packed {
        logic              div_ready;
        logic              acc_ready;
        logic              ofifo_rd;
        logic [ADDR_W-1:0] qkmem_add;
        logic [ADDR_W-1:0] pmem_add;
        logic              execute;
        logic              load;
        logic              qmem_rd;
        logic              qmem_wr;
        logic              kmem_rd;
        logic              kmem_wr;
        logic              pmem_rd;
        logic              pmem_wr;
    } inst_t;

    state_t          state, nxt_state;
    logic [CW-1:0]   cnt, nxt_cnt;
    logic [SW-1:0]   sub, nxt_sub;
    logic [2:0]      gap_from, nxt_gap_from;
    logic [5:0]      en, nxt_en;
    logic            accept;
    inst_t           inst_d;

    // First enabled phase strictly after phase code p (1=QWR .. 6=SFP), else DONE.
    function automatic state_t next_after(input logic [2:0] p, input logic [5:0] e);
        state_t s;
        s = S_DONE;
        for (int i = 5; i >= 0; i--) begin
            if (e[i] && (i + 1 > int'(p))) begin
                case (i)
                    0:       s = S_QWR;
                    1:       s = S_KWR;
                    2:       s = S_KLOAD;
                    3:       s = S_EXEC;
                    4:       s = S_OFIFO;
                    default: s = S_SFP;
                endcase
            end
        end
        return s;
    endfunction

    function automatic logic [2:0] phase_code(input state_t s);
        case (s)
            S_IDLE:  return 3'd0;
            S_QWR:   return 3'd1;
            S_KWR:   return 3'd2;
            S_KLOAD: return 3'd3;
            S_EXEC:  return 3'd4;
            S_OFIFO: return 3'd5;
            S_SFP:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // A row is taken whenever a request meets valid data; abort discards it.
    assign accept = data_req & data_vld & ~abort;

    // Next-state and counter logic; abort overrides every transition.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        nxt_state    = state;
        nxt_cnt      = cnt;
        nxt_sub      = sub;
        nxt_gap_from = gap_from;
        nxt_en       = en;
        case (state)
            S_IDLE: if (start) begin
                nxt_en    = phase_en;
                nxt_state = next_after(3'd0, phase_en);
                nxt_cnt   = '0;
            end
            S_QWR: if (accept) begin
                if (cnt == CW'(Q_DEPTH - 1)) begin
                    nxt_cnt = '0;
                    if (en[1]) begin
                        nxt_state = S_KWR;
                    end else begin
                        // One-cycle tail so the last Q write is not hidden by the next phase.
                        nxt_state    = S_GAP;
                        nxt_sub      = '0;
                        nxt_gap_from = 3'd1;
                    end
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_KWR: if (accept) begin
                if (cnt == CW'(COL - 1)) begin
                    nxt_cnt      = '0;
                    nxt_state    = S_GAP;
                    nxt_sub      = SW'(GAP - 1);
                    nxt_gap_from = 3'd2;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end
            S_KLOAD: if (cnt == CW'(COL + 1)) begin
                nxt_cnt      = '0;
                nxt_state    = S_GAP;
                nxt_sub      = SW'(GAP - 1);
                nxt_gap_from = 3'd3;
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
            S_EXEC, S_OFIFO: if (cnt == CW'(Q_DEPTH - 1)) begin
                nxt_cnt      = '0;
                nxt_state    = S_GAP;
                nxt_sub      = SW'(GAP - 1);
                nxt_gap_from = phase_code(state);
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
            S_SFP: if (sub == SW'(SFP_LEN - 1)) begin
                nxt_sub = '0;
                if (cnt == CW'(Q_DEPTH - 1)) begin
                    nxt_cnt   = '0;
                    nxt_state = S_DONE;
                end else begin
                    nxt_cnt = cnt + 1'b1;
                end
            end else begin
                nxt_sub = sub + 1'b1;
            end
            S_GAP: if (sub == '0) begin
                nxt_state = next_after(gap_from, en);
            end else begin
                nxt_sub = sub - 1'b1;
            end
            default: nxt_state = S_IDLE;
        endcase
        if (abort) begin
            nxt_state    = S_IDLE;
            nxt_cnt      = '0;
            nxt_sub      = '0;
            nxt_gap_from = '0;
        end
    end

    // Instruction word for the coming cycle, decoded from the next state and counters.
    always_comb begin
        inst_d = '0;
        case (nxt_state)
            S_KLOAD: begin
                inst_d.load = 1'b1;
                if (nxt_cnt != '0 && nxt_cnt <= CW'(COL)) begin
                    inst_d.kmem_rd   = 1'b1;
                    inst_d.qkmem_add = ADDR_W'(nxt_cnt - 1'b1);
                end
            end
            S_EXEC: begin
                inst_d.execute   = 1'b1;
                inst_d.qmem_rd   = 1'b1;
                inst_d.qkmem_add = ADDR_W'(nxt_cnt);
            end
            S_OFIFO: begin
                inst_d.ofifo_rd = 1'b1;
                inst_d.pmem_wr  = 1'b1;
                inst_d.pmem_add = ADDR_W'(nxt_cnt);
            end
            S_SFP: begin
                inst_d.pmem_rd   = 1'b1;
                inst_d.pmem_add  = ADDR_W'(nxt_cnt);
                inst_d.acc_ready = (nxt_sub == SW'(2)) || (nxt_sub == SW'(3));
                inst_d.div_ready = (nxt_sub >= SW'(5));
            end
            default: ;
        endcase
        // A row accepted this cycle is written next cycle, overlapping the next state.
        if (accept) begin
            inst_d           = '0;
            inst_d.qkmem_add = ADDR_W'(cnt);
            inst_d.qmem_wr   = (state == S_QWR);
            inst_d.kmem_wr   = (state == S_KWR);
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sub        <= '0;
            gap_from   <= '0;
            en         <= '0;
            inst       <= '0;
            mem_out    <= '0;
            data_req   <= 1'b0;
            data_sel   <= 1'b0;
            data_idx   <= '0;
            sfp_sample <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            phase      <= '0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            sub        <= nxt_sub;
            gap_from   <= nxt_gap_from;
            en         <= nxt_en;
            inst       <= inst_d;
            if (accept) begin
                mem_out <= data_in;
            end
            data_req   <= (nxt_state == S_QWR) || (nxt_state == S_KWR);
            data_sel   <= (nxt_state == S_KWR);
            data_idx   <= ((nxt_state == S_QWR) || (nxt_state == S_KWR)) ? ADDR_W'(nxt_cnt) : '0;
            sfp_sample <= (nxt_state == S_SFP) && (nxt_sub == SW'(SFP_LEN - 1));
            busy       <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done       <= (nxt_state == S_DONE);
            phase      <= phase_code(nxt_state);
        end
    end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Directed bench for qk_inst_sequencer at default parameters: full run
// checked against a table of hand-computed instruction words, plus stall,
// EXEC-only, abort and mid-run reset sequences.
module tb_qk_inst_sequencer;

    localparam int BW = 4, PR = 16, COL = 8, Q_DEPTH = 8, ADDR_W = 4;
    localparam int GAP = 10, SFP_LEN = 8, INST_W = 19, DW = PR * BW;

    logic              clk = 1'b0;
    logic              reset, start, abort, data_vld;
    logic [5:0]        phase_en;
    logic [DW-1:0]     data_in;
    logic              data_req, data_sel, sfp_sample, busy, done;
    logic [ADDR_W-1:0] data_idx;
    logic [INST_W-1:0] inst;
    logic [DW-1:0]     mem_out;
    logic [2:0]        phase;

    qk_inst_sequencer #(
        .BW(BW), .PR(PR), .COL(COL), .Q_DEPTH(Q_DEPTH), .ADDR_W(ADDR_W),
        .GAP(GAP), .SFP_LEN(SFP_LEN), .INST_W(INST_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .phase_en(phase_en), .data_in(data_in), .data_vld(data_vld),
        .data_req(data_req), .data_sel(data_sel), .data_idx(data_idx),
        .inst(inst), .mem_out(mem_out), .sfp_sample(sfp_sample),
        .busy(busy), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle trace: index n is the state after the n-th edge following start.
    logic [INST_W-1:0] t_inst [0:255];
    logic [DW-1:0]     t_mem  [0:255];
    logic [ADDR_W-1:0] t_idx  [0:255];
    logic [2:0]        t_phase[0:255];
    logic              t_req  [0:255];
    logic              t_busy [0:255];
    logic              t_done [0:255];
    logic              t_sfp  [0:255];

    typedef struct {
        string             name;
        int                cyc;
        logic [INST_W-1:0] inst;
        logic [2:0]        phase;
        logic              busy;
        logic              req;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source row content encodes its kind and index so mem_out is traceable.
    function automatic logic [DW-1:0] row_of(input logic sel, input logic [ADDR_W-1:0] idx);
        return {8'hA5, 7'h0, sel, 4'h0, idx, 40'h0123456789};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        data_in = row_of(data_sel, data_idx);
    endtask

    task automatic capture(input int ncyc, input int stall_a, input int stall_b, input int start_at);
        for (int n = 1; n <= ncyc; n++) begin
            tick();
            t_inst[n]  = inst;
            t_mem[n]   = mem_out;
            t_idx[n]   = data_idx;
            t_phase[n] = phase;
            t_req[n]   = data_req;
            t_busy[n]  = busy;
            t_done[n]  = done;
            t_sfp[n]   = sfp_sample;
            start      = (n == start_at);
            data_vld   = !(n == stall_a || n == stall_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int nb, nd, nr, found;

        tbl[0]  = '{"qwr_first_req",   1,   19'h00000, 3'd1, 1'b1, 1'b1};
        tbl[1]  = '{"qwr_idx0",        2,   19'h00010, 3'd1, 1'b1, 1'b1};
        tbl[2]  = '{"qwr_idx3",        5,   19'h03010, 3'd1, 1'b1, 1'b1};
        tbl[3]  = '{"qwr_idx7_in_kwr", 9,   19'h07010, 3'd2, 1'b1, 1'b1};
        tbl[4]  = '{"kwr_idx5",        15,  19'h05004, 3'd2, 1'b1, 1'b1};
        tbl[5]  = '{"kwr_idx7_in_gap", 17,  19'h07004, 3'd7, 1'b1, 1'b0};
        tbl[6]  = '{"gap_last",        26,  19'h00000, 3'd7, 1'b1, 1'b0};
        tbl[7]  = '{"kload_k0",        27,  19'h00040, 3'd3, 1'b1, 1'b0};
        tbl[8]  = '{"kload_k1",        28,  19'h00048, 3'd3, 1'b1, 1'b0};
        tbl[9]  = '{"kload_k8",        35,  19'h07048, 3'd3, 1'b1, 1'b0};
        tbl[10] = '{"kload_k9",        36,  19'h00040, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{"exec_idx0",       47,  19'h000A0, 3'd4, 1'b1, 1'b0};
        tbl[12] = '{"exec_idx7",       54,  19'h070A0, 3'd4, 1'b1, 1'b0};
        tbl[13] = '{"ofifo_idx2",      67,  19'h10201, 3'd5, 1'b1, 1'b0};
        tbl[14] = '{"sfp_r0_c0",       83,  19'h00002, 3'd6, 1'b1, 1'b0};
        tbl[15] = '{"sfp_r1_c2",       93,  19'h20102, 3'd6, 1'b1, 1'b0};
        tbl[16] = '{"sfp_r1_c6",       97,  19'h40102, 3'd6, 1'b1, 1'b0};
        tbl[17] = '{"sfp_r7_c7",       146, 19'h40702, 3'd6, 1'b1, 1'b0};
        tbl[18] = '{"done_cycle",      147, 19'h00000, 3'd7, 1'b0, 1'b0};
        tbl[19] = '{"idle_after",      148, 19'h00000, 3'd0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; phase_en = 6'h3F;
        data_vld = 1'b1; data_in = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_ctl_%0d", i), 64'({inst, busy, done, data_req, sfp_sample, phase}), 64'h0);
        end
        check("idle_mem_out", 64'(mem_out), 64'h0);

        // Full run, all phases, data always valid.
        start = 1'b1;
        capture(160, -1, -1, -1);
        for (int i = 0; i < 20; i++) begin
            check(tbl[i].name, 64'({t_inst[tbl[i].cyc], t_phase[tbl[i].cyc], t_busy[tbl[i].cyc], t_req[tbl[i].cyc]}),
                  64'({tbl[i].inst, tbl[i].phase, tbl[i].busy, tbl[i].req}));
        end
        check("full_mem_q3", 64'(t_mem[5]), 64'(row_of(1'b0, 4'd3)));
        check("full_mem_k5", 64'(t_mem[15]), 64'(row_of(1'b1, 4'd5)));
        check("full_sfp_sample_c7", 64'({t_sfp[97], t_sfp[98]}), 64'b01);
        check("full_done_at_147", 64'(t_done[147]), 64'h1);
        nb = 0; nd = 0;
        for (int n = 1; n <= 160; n++) begin
            if (t_busy[n]) nb++;
            if (t_done[n]) nd++;
        end
        check("full_busy_cycles", 64'(nb), 64'd146);
        check("full_done_pulses", 64'(nd), 64'd1);

        // Stall at Q idx 3 for two cycles, plus a start pulse mid-run that must be ignored.
        start = 1'b1;
        capture(160, 4, 5, 50);
        check("stall_idx3_req", 64'(t_idx[4]), 64'd3);
        check("stall_bubbles", 64'({t_inst[5], t_inst[6]}), 64'h0);
        check("stall_idx_held", 64'(t_idx[6]), 64'd3);
        check("stall_write_q3", 64'(t_inst[7]), 64'h03010);
        check("stall_mem_held", 64'(t_mem[6]), 64'(row_of(1'b0, 4'd2)));
        check("stall_mem_q3", 64'(t_mem[7]), 64'(row_of(1'b0, 4'd3)));
        check("stall_done_at_149", 64'({t_done[148], t_done[149]}), 64'b01);
        nb = 0;
        for (int n = 1; n <= 160; n++) if (t_busy[n]) nb++;
        check("stall_busy_cycles", 64'(nb), 64'd148);

        // EXEC only.
        phase_en = 6'b001000;
        start = 1'b1;
        capture(30, -1, -1, -1);
        check("exec_only_first", 64'({t_inst[1], t_phase[1]}), 64'({19'h000A0, 3'd4}));
        check("exec_only_last", 64'({t_inst[8], t_phase[8]}), 64'({19'h070A0, 3'd4}));
        check("exec_only_gap", 64'({t_inst[9], t_phase[9], t_busy[18], t_phase[18]}), 64'({19'h0, 3'd7, 1'b1, 3'd7}));
        check("exec_only_done", 64'({t_done[18], t_done[19], t_busy[19]}), 64'b010);
        nr = 0; nb = 0;
        for (int n = 1; n <= 30; n++) begin
            if (t_req[n]) nr++;
            if (t_busy[n]) nb++;
        end
        check("exec_only_no_req", 64'(nr), 64'd0);
        check("exec_only_busy", 64'(nb), 64'd18);

        // Abort at EXEC idx 4.
        phase_en = 6'h3F;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (inst == 19'h040A0) found = 1;
        end
        check("abort_reach_exec4", 64'(found), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outputs", 64'({inst, busy, done, data_req, phase}), 64'h0);
        check("abort_mem_held", 64'(mem_out), 64'(row_of(1'b1, 4'd7)));
        nd = 0; nb = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) nd++;
            if (busy) nb++;
        end
        check("abort_no_done", 64'({nd, nb}), 64'h0);
        start = 1'b1;
        capture(3, -1, -1, -1);
        check("rerun_req0", 64'({t_req[1], t_busy[1], t_idx[1], t_phase[1]}), 64'({1'b1, 1'b1, 4'd0, 3'd1}));
        check("rerun_q0", 64'(t_inst[2]), 64'h00010);

        // Reset during SFP row 3.
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            tick();
            if (phase == 3'd6 && inst == 19'h00302) found = 1;
        end
        check("reset_reach_sfp3", 64'(found), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_outputs", 64'({inst, busy, done, data_req, data_sel, data_idx, sfp_sample, phase}), 64'h0);
        check("reset_mem_out", 64'(mem_out), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
